// File: rtl/ipml_fifo_wr_skid_adapter.sv
// rtl/ipml_fifo_wr_skid_adapter.sv - valid/ready to FIFO write-port adapter with 2-entry skid buffer
module ipml_fifo_wr_skid_adapter #(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [c_DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [c_DATA_WIDTH-1:0] wr_data,
    output logic                    wr_en,
    input  logic                    wr_vld,
    output logic                    idle,
    output logic [c_CNT_WIDTH-1:0]  wr_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [c_DATA_WIDTH-1:0] out_q, out_d;
    logic [c_DATA_WIDTH-1:0] skid_q, skid_d;
    logic                    s_ready_q, s_ready_d;
    logic [c_CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic                    push, pop;

    assign push = s_valid & s_ready_q;
    assign pop  = (state_q != EMPTY) & wr_vld;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        wr_cnt_d = wr_cnt_q;
        if (pop) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = HALF;
                    out_d   = s_data;
                end
            end
            HALF: begin
                if (push && !pop) begin
                    state_d = FULL;
                    skid_d  = s_data;
                end else if (push && pop) begin
                    out_d = s_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Upstream is stalled here, so only the drain path matters.
                if (pop) begin
                    state_d = HALF;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        s_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wr_data = out_q;
    assign wr_en   = (state_q != EMPTY);
    assign idle    = (state_q == EMPTY);
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_ipml_fifo_wr_skid_adapter.sv
// tb/tb_ipml_fifo_wr_skid_adapter.sv - scoreboard bench for ipml_fifo_wr_skid_adapter
module tb_ipml_fifo_wr_skid_adapter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_vld = 1'b0;
    logic          idle;
    logic [CW-1:0] wr_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic          vld_toggle = 1'b0;

    ipml_fifo_wr_skid_adapter #(
        .c_DATA_WIDTH(DW),
        .c_CNT_WIDTH (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .wr_data(wr_data),
        .wr_en  (wr_en),
        .wr_vld (wr_vld),
        .idle   (idle),
        .wr_cnt (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    // Monitor: the model is "words accepted but not yet written", held in exp_q.
    initial begin : monitor
        logic          after_rst;
        logic [CW-1:0] cnt_m;
        logic          exp_en;
        logic [DW-1:0] w;
        after_rst = 1'b1;
        cnt_m     = '0;
        forever begin
            @(negedge clk);
            #2;
            exp_en = (exp_q.size() != 0);
            chk("wr_en", wr_en, exp_en);
            chk("idle", idle, !exp_en);
            chk("s_ready", s_ready, after_rst ? 1'b0 : (exp_q.size() < 2));
            chk("wr_cnt", wr_cnt, cnt_m);
            if (after_rst) chk("wr_data_rst", wr_data, 0);
            if (!rst_n) begin
                after_rst = 1'b1;
                cnt_m     = '0;
            end else begin
                after_rst = 1'b0;
                if (exp_en && wr_vld) begin
                    w = exp_q.pop_front();
                    chk("wr_data", wr_data, w);
                    cnt_m = cnt_m + 1'b1;
                end
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic vld,
                        input logic rn, output logic acc);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        wr_vld  = vld;
        rst_n   = rn;
        #3;
        acc = v && s_ready && rn;
        if (acc) exp_q.push_back(d);
        if (!rn) exp_q.delete();
    endtask

    function automatic logic pick_vld(input int mode);
        case (mode)
            0: return 1'b1;
            1: begin vld_toggle = ~vld_toggle; return vld_toggle; end
            2: return 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic send_words(input int n, input logic [DW-1:0] base, input int mode);
        logic acc;
        int   tries;
        for (int i = 0; i < n; i++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc) begin
                step(1'b1, base + DW'(i), pick_vld(mode), 1'b1, acc);
                tries++;
                if (!acc && tries > 60) begin
                    bound_fail("send_word");
                    break;
                end
            end
        end
    endtask

    task automatic drain();
        logic acc;
        int   t;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            step(1'b0, DW'($urandom), 1'b1, 1'b1, acc);
            t++;
        end
        if (exp_q.size() != 0) bound_fail("drain");
        step(1'b0, '0, 1'b1, 1'b1, acc);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic          acc;
        logic          cur_v;
        logic [DW-1:0] cur_d;

        // Reset and idle
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_idle", idle, 1);
        chk("rst_wr_cnt", wr_cnt, 0);
        step(1'b0, '0, 1'b1, 1'b1, acc);
        chk("ready_before_edge", s_ready, 0);
        step(1'b0, '0, 1'b1, 1'b1, acc);
        chk("ready_after_release", s_ready, 1);

        // Streaming 16 words
        send_words(16, 32'h1, 0);
        drain();
        chk("stream_cnt", wr_cnt, 0);

        // Back-pressure with upstream stall on the third word
        step(1'b1, 32'hA, 1'b0, 1'b1, acc);
        chk("bp_acc_a", acc, 1);
        step(1'b1, 32'hB, 1'b0, 1'b1, acc);
        chk("bp_acc_b", acc, 1);
        repeat (3) begin
            step(1'b1, 32'hC, 1'b0, 1'b1, acc);
            chk("bp_c_held", acc, 0);
            chk("bp_full_ready", s_ready, 0);
        end
        send_words(1, 32'hC, 0);
        drain();
        chk("bp_cnt", wr_cnt, 3);

        // Alternating wr_vld, 20 words
        send_words(20, 32'h100, 1);
        drain();
        chk("alt_cnt", wr_cnt, (3 + 20) % 16);

        // Reset while FULL discards both buffered words
        step(1'b1, 32'h11, 1'b0, 1'b1, acc);
        step(1'b1, 32'h22, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("full_ready", s_ready, 0);
        chk("full_idle", idle, 0);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b1, acc);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_cnt", wr_cnt, 0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b1, acc);

        // Counter wrap at 4 bits
        send_words(15, 32'h200, 0);
        drain();
        chk("wrap_cnt15", wr_cnt, 15);
        send_words(1, 32'h20F, 0);
        drain();
        chk("wrap_cnt16", wr_cnt, 0);
        send_words(1, 32'h210, 3);
        drain();
        chk("wrap_cnt17", wr_cnt, 1);

        // Randomized traffic with occasional resets
        cur_v = 1'b0;
        cur_d = '0;
        for (int i = 0; i < 2000; i++) begin
            logic rn;
            rn = ($urandom_range(0, 199) != 0);
            step(cur_v, cur_d, 1'($urandom_range(0, 1)), rn, acc);
            if (!cur_v || acc || !rn) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = DW'($urandom);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
